// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler: 16x oversampled 8N1 receiver with mid-bit majority vote; define UART_RX_PARITY_EN for 8E1
module uart_rx_oversampler #(
  parameter int comm_clk_frequency = 200000000,
  parameter int baud_rate = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       tx_new_byte,
  output logic [7:0] tx_byte,
  output logic       tx_frame_error,
  output logic       tx_parity_error
);
  localparam int OVS_DIV = comm_clk_frequency / (baud_rate * 16);
  localparam int DW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  if (OVS_DIV < 1) begin : g_ovs_check
    $error("uart_rx_oversampler: OVS_DIV must be at least 1");
  end
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP, BREAK
  } state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0] hist_q, hist_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0] s_q, s_d, brk_q, brk_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, byte_q, byte_d;
  logic new_byte_q, new_byte_d, ferr_q, ferr_d;
  logic fall, tick, vote_tick, wrap, vote, par_ok;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
  assign par_ok = ~^{shift_q, par_q};
  assign tx_parity_error = perr_q;
`else
  assign par_ok = 1'b1;
  assign tx_parity_error = 1'b0;
`endif
  assign fall = rx_prev_q & ~rx_s2_q;
  assign tick = (state_q != IDLE) && (div_q == DW'(OVS_DIV - 1));
  assign vote_tick = tick && (s_q == 4'd9);
  assign wrap = tick && (s_q == 4'd15);
  // samples taken at s = 7 and 8 sit in the history; s = 9 is the live synchronized value
  assign vote = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s2_q) | (hist_q[0] & rx_s2_q);
  assign tx_new_byte = new_byte_q;
  assign tx_byte = byte_q;
  assign tx_frame_error = ferr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      hist_q <= 2'b11;
      div_q <= '0;
      s_q <= '0;
      brk_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      byte_q <= '0;
      new_byte_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      hist_q <= hist_d;
      div_q <= div_d;
      s_q <= s_d;
      brk_q <= brk_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      byte_q <= byte_d;
      new_byte_q <= new_byte_d;
      ferr_q <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q <= par_d;
      perr_q <= perr_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    hist_d = tick ? {hist_q[0], rx_s2_q} : hist_q;
    div_d = (state_q == IDLE || tick) ? '0 : div_q + DW'(1);
    s_d = (state_q == IDLE) ? 4'd0 : tick ? s_q + 4'd1 : s_q;
    brk_d = brk_q;
    bit_d = bit_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      IDLE: state_d = fall ? START : IDLE;
      START: begin
        if (vote_tick && vote) state_d = IDLE;
        else if (wrap) begin
          state_d = DATA;
          bit_d = 3'd0;
        end
      end
      DATA: begin
        shift_d = vote_tick ? {vote, shift_q[7:1]} : shift_q;
        if (wrap) begin
          bit_d = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? AFTER_DATA : DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        par_d = vote_tick ? vote : par_q;
        state_d = wrap ? STOP : PARITY;
      end
`endif
      STOP: begin
        brk_d = 4'd0;
        state_d = !vote_tick ? STOP : vote ? IDLE : BREAK;
      end
      BREAK: begin
        brk_d = !tick ? brk_q : rx_s2_q ? brk_q + 4'd1 : 4'd0;
        state_d = (tick && rx_s2_q && brk_q == 4'd15) ? IDLE : BREAK;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    new_byte_d = (state_q == STOP) && vote_tick && vote && par_ok;
    ferr_d = (state_q == STOP) && vote_tick && !vote;
`ifdef UART_RX_PARITY_EN
    perr_d = (state_q == STOP) && vote_tick && vote && !par_ok;
`endif
    byte_d = new_byte_d ? shift_q : byte_q;
  end
endmodule
